uart_packet_rx: RTL and testbench

Host-to-board end of the debug UART link: receives 8N1 serial bytes on `rx`, reassembles fixed 7-byte debug packets of the form {sync, header(kind, addr), 32-bit data, checksum}, and presents each validated packet as a one-cycle strobe with kind/addr/data fields. It sits beside the debug packet transmitter on the board top level. It gives the host a command path into the CPU debug logic, using the same kind/addr/data field layout the transmitter sends.

---
 rtl/uart_pkt_defs.sv | 35 +++
 rtl/uart_byte_rx.sv | 131 +++++++++++++
 rtl/uart_packet_rx.sv | 141 ++++++++++++++
 tb/tb_uart_packet_rx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_defs.sv
// Shared definitions for the debug UART packet link: sync byte, kind codes,
// FSM state encodings and the decoded packet payload.
package uart_pkt_defs;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  localparam logic [1:0] KIND_REG   = 2'b00;
  localparam logic [1:0] KIND_ALU   = 2'b01;
  localparam logic [1:0] KIND_INST  = 2'b10;
  localparam logic [1:0] KIND_OTHER = 2'b11;

  typedef enum logic [2:0] {
    PKT_HUNT = 3'd0,
    PKT_HDR  = 3'd1,
    PKT_D3   = 3'd2,
    PKT_D2   = 3'd3,
    PKT_D1   = 3'd4,
    PKT_D0   = 3'd5,
    PKT_CSUM = 3'd6
  } pkt_state_t;

  typedef enum logic [1:0] {
    BRX_IDLE  = 2'd0,
    BRX_START = 2'd1,
    BRX_DATA  = 2'd2,
    BRX_STOP  = 2'd3
  } brx_state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } pkt_fields_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, stop-bit check.
module uart_byte_rx
  import uart_pkt_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Two synchronizer flops plus one history flop for falling-edge detection
  logic rx_s1, rx_s2, rx_s3;

  brx_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= BRX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;

    case (state_q)
      BRX_IDLE: begin
        cnt_d = '0;
        if (rx_s3 && !rx_s2) begin
          state_d = BRX_START;
        end
      end

      // Mid start bit: a high line means the edge was a glitch
      BRX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s2 ? BRX_IDLE : BRX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BRX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s2, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = BRX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leave at mid stop bit so back-to-back start edges are not missed
      BRX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = BRX_IDLE;
          if (rx_s2) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = BRX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_packet_rx.sv
// Debug UART packet receiver: reassembles 7-byte {sync, hdr, data, csum}
// packets and strobes validated fields or a drop indication.
module uart_packet_rx
  import uart_pkt_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  output logic        pkt_valid,
  output logic [1:0]  pkt_kind,
  output logic [4:0]  pkt_addr,
  output logic [31:0] pkt_data,
  output logic        pkt_err,
  output logic        byte_valid,
  output logic [7:0]  byte_data
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS);

  logic frame_err;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  pkt_state_t      state_q, state_d;
  pkt_fields_t     work_q, work_d;
  pkt_fields_t     out_q, out_d;
  logic [7:0]      xor_q, xor_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            pkt_err_q, pkt_err_d;
  logic            abort;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= PKT_HUNT;
      work_q      <= '0;
      out_q       <= '0;
      xor_q       <= '0;
      to_cnt_q    <= '0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_q       <= out_d;
      xor_q       <= xor_d;
      to_cnt_q    <= to_cnt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_d       = out_q;
    xor_d       = xor_q;
    to_cnt_d    = to_cnt_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;

    // Inter-byte idle counter; saturates so it never wraps back to zero
    if (byte_valid || (state_q == PKT_HUNT)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // frame_err and byte_valid are exclusive, so abort never races a byte
    abort = (state_q != PKT_HUNT) && !byte_valid &&
            (frame_err || (to_cnt_q == TO_LIMIT));

    if (abort) begin
      pkt_err_d = 1'b1;
      state_d   = PKT_HUNT;
    end else if (byte_valid) begin
      case (state_q)
        PKT_HUNT: begin
          if (byte_data == SYNC_BYTE) begin
            state_d = PKT_HDR;
          end
        end

        PKT_HDR: begin
          if (byte_data[7]) begin
            pkt_err_d = 1'b1;
            state_d   = PKT_HUNT;
          end else begin
            work_d.kind = byte_data[6:5];
            work_d.addr = byte_data[4:0];
            xor_d       = byte_data;
            state_d     = PKT_D3;
          end
        end

        PKT_D3, PKT_D2, PKT_D1, PKT_D0: begin
          work_d.data = {work_q.data[23:0], byte_data};
          xor_d       = xor_q ^ byte_data;
          case (state_q)
            PKT_D3:  state_d = PKT_D2;
            PKT_D2:  state_d = PKT_D1;
            PKT_D1:  state_d = PKT_D0;
            default: state_d = PKT_CSUM;
          endcase
        end

        PKT_CSUM: begin
          if (byte_data == xor_q) begin
            out_d       = work_q;
            pkt_valid_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          state_d = PKT_HUNT;
        end

        default: state_d = PKT_HUNT;
      endcase
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_err   = pkt_err_q;
  assign pkt_kind  = out_q.kind;
  assign pkt_addr  = out_q.addr;
  assign pkt_data  = out_q.data;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx: directed serial packets against a
// byte-list packet model, checked every cycle by one compare process.
module tb_uart_packet_rx;

  localparam int CPB     = 16;
  localparam int TIMEOUT = 20 * CPB;

  logic        clk;
  logic        resetn;
  logic        rx;
  logic        pkt_valid;
  logic [1:0]  pkt_kind;
  logic [4:0]  pkt_addr;
  logic [31:0] pkt_data;
  logic        pkt_err;
  logic        byte_valid;
  logic [7:0]  byte_data;

  uart_packet_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .pkt_valid  (pkt_valid),
    .pkt_kind   (pkt_kind),
    .pkt_addr   (pkt_addr),
    .pkt_data   (pkt_data),
    .pkt_err    (pkt_err),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] seq[$];
  logic [7:0] m_buf[7];
  int         m_len;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_bv    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet model: works on whole byte lists ----------------
  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.kind = '0; e.addr = '0; e.data = '0;
    ev_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t        e;
    logic [7:0] hdr;
    logic [7:0] x;
    byte_q.push_back(b);
    if (m_len == 0) begin
      if (b == 8'hA5) begin m_buf[0] = b; m_len = 1; end
    end else if (m_len == 1 && b[7]) begin
      push_err();
      m_len = 0;
    end else begin
      m_buf[m_len] = b;
      m_len++;
      if (m_len == 7) begin
        hdr = m_buf[1];
        x = m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4] ^ m_buf[5];
        if (x == m_buf[6]) begin
          e.is_err = 1'b0;
          e.kind   = hdr[6:5];
          e.addr   = hdr[4:0];
          e.data   = {m_buf[2], m_buf[3], m_buf[4], m_buf[5]};
          ev_q.push_back(e);
        end else begin
          push_err();
        end
        m_len = 0;
      end
    end
  endtask

  // Framing error or long idle: drops any partial packet
  task automatic model_abort();
    if (m_len != 0) push_err();
    m_len = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) model_byte(b);
    else         model_abort();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b1);
  endtask

  task automatic idle(input int bits);
    if (bits * CPB >= TIMEOUT) model_abort();
    rx = 1'b1;
    tick(bits * CPB);
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_evt_pending"}, 64'(ev_q.size()), 64'd0);
    chk({name, "_byte_pending"}, 64'(byte_q.size()), 64'd0);
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    ev_t        e;
    logic [7:0] eb;
    logic [38:0] shown;
    bit         prev_bv;
    shown   = '0;
    prev_bv = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        shown   = '0;
        prev_bv = 1'b0;
      end else begin
        if (byte_valid) begin
          n_bv++;
          if (byte_q.size() == 0) begin
            chk("byte_unexpected", 64'(byte_data), 64'hFFFF);
          end else begin
            eb = byte_q.pop_front();
            chk("byte_data", 64'(byte_data), 64'(eb));
          end
        end
        chk("valid_err_exclusive", 64'(pkt_valid & pkt_err), 64'd0);
        if (pkt_valid || pkt_err) begin
          if (pkt_valid) n_valid++;
          if (pkt_err)   n_err++;
          if (ev_q.size() == 0) begin
            chk("pkt_unexpected", {pkt_valid, pkt_err}, 64'd0);
          end else begin
            e = ev_q.pop_front();
            chk("pkt_is_err", 64'(pkt_err), 64'(e.is_err));
            if (!e.is_err) begin
              chk("valid_after_byte", 64'(prev_bv), 64'd1);
              shown = {e.kind, e.addr, e.data};
            end
          end
        end
        chk("pkt_fields", 64'({pkt_kind, pkt_addr, pkt_data}), 64'(shown));
        prev_bv = byte_valid;
      end
    end
  end

  // ---------------- directed tests ----------------
  int v0, e0, b0;

  initial begin : main
    rx     = 1'b1;
    resetn = 1'b0;
    m_len  = 0;
    tick(4);
    @(negedge clk);
    chk("reset_outputs",
        64'({pkt_valid, pkt_err, byte_valid, pkt_kind, pkt_addr, pkt_data, byte_data}), 64'd0);
    tick(1);
    resetn = 1'b1;
    idle(2);

    // 1: basic packet
    v0 = n_valid; e0 = n_err;
    seq = '{8'hA5, 8'h24, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h06};
    send_seq();
    idle(2);
    chk("t1_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("t1_err_cnt", 64'(n_err - e0), 64'd0);
    chk("t1_kind", 64'(pkt_kind), 64'h1);
    chk("t1_addr", 64'(pkt_addr), 64'h4);
    chk("t1_data", 64'(pkt_data), 64'hDEADBEEF);
    chk_drained("t1");

    // 2: bad checksum keeps fields, then a good packet replaces them
    v0 = n_valid; e0 = n_err;
    seq = '{8'hA5, 8'h24, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h07};
    send_seq();
    idle(2);
    chk("t2_err_cnt", 64'(n_err - e0), 64'd1);
    chk("t2_valid_cnt", 64'(n_valid - v0), 64'd0);
    chk("t2_data_held", 64'(pkt_data), 64'hDEADBEEF);
    seq = '{8'hA5, 8'h43, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4B};
    send_seq();
    idle(2);
    chk("t2_valid_cnt2", 64'(n_valid - v0), 64'd1);
    chk("t2_kind", 64'(pkt_kind), 64'h2);
    chk("t2_addr", 64'(pkt_addr), 64'h3);
    chk("t2_data", 64'(pkt_data), 64'h12345678);
    chk_drained("t2");

    // 3: leading junk ignored; sync value inside data is plain data
    v0 = n_valid; e0 = n_err;
    seq = '{8'h00, 8'h13, 8'hA5, 8'h24, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h06};
    send_seq();
    idle(2);
    chk("t3_data_a", 64'(pkt_data), 64'hDEADBEEF);
    seq = '{8'hA5, 8'h24, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h24};
    send_seq();
    idle(2);
    chk("t3_valid_cnt", 64'(n_valid - v0), 64'd2);
    chk("t3_err_cnt", 64'(n_err - e0), 64'd0);
    chk("t3_data_b", 64'(pkt_data), 64'hA5A5A5A5);
    chk_drained("t3");

    // 4: inter-byte timeout, then recovery
    v0 = n_valid; e0 = n_err;
    seq = '{8'hA5, 8'h24, 8'hDE};
    send_seq();
    idle(30);
    chk("t4_err_cnt", 64'(n_err - e0), 64'd1);
    seq = '{8'hA5, 8'h24, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h06};
    send_seq();
    idle(2);
    chk("t4_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("t4_err_cnt2", 64'(n_err - e0), 64'd1);
    chk("t4_data", 64'(pkt_data), 64'hDEADBEEF);
    chk_drained("t4");

    // 5: framing error mid-packet, header bit 7 set, start-bit glitch
    e0 = n_err; b0 = n_bv;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h24, 1'b0);
    idle(30);
    chk("t5_ferr_bv", 64'(n_bv - b0), 64'd1);
    chk("t5_ferr_err", 64'(n_err - e0), 64'd1);
    seq = '{8'hA5, 8'h80};
    send_seq();
    idle(2);
    chk("t5_hdr_err", 64'(n_err - e0), 64'd2);
    b0 = n_bv;
    rx = 1'b0;
    tick(4);
    idle(4);
    chk("t5_glitch_bv", 64'(n_bv - b0), 64'd0);
    chk_drained("t5");

    // 6: reset in the middle of a data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h24, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB * 3);
    resetn = 1'b0;
    m_len  = 0;
    ev_q.delete();
    byte_q.delete();
    tick(3);
    @(negedge clk);
    chk("t6_reset_outputs",
        64'({pkt_valid, pkt_err, byte_valid, pkt_kind, pkt_addr, pkt_data, byte_data}), 64'd0);
    tick(1);
    resetn = 1'b1;
    idle(2);
    v0 = n_valid; e0 = n_err;
    seq = '{8'hA5, 8'h43, 8'h12, 8'h34, 8'h56, 8'h78, 8'h4B};
    send_seq();
    idle(2);
    chk("t6_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("t6_err_cnt", 64'(n_err - e0), 64'd0);
    chk("t6_data", 64'(pkt_data), 64'h12345678);
    chk_drained("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
